mux_n_to_one_arb: RTL and testbench

- Parametrised N-input, WIDTH-bit successor to the 2:1 datapath mux.
- Selection is not driven by an external op bit. An internal arbiter picks one lane among the lanes that assert valid, using either fixed-priority or round-robin order.
- The winning data is registered into a single-entry output stage with a valid/ready handshake.
- Sits between several datapath producers (ALU/load results, 64-bit) and one shared consumer, such as a writeback port.

---
 rtl/mux_n_to_one_arb_pkg.sv | 20 ++
 rtl/mux_n_to_one_arb_if.sv | 40 ++++
 rtl/mux_n_to_one_arb_arb_grant_n.sv | 41 ++++
 rtl/mux_n_to_one_arb.sv | 86 ++++++++
 tb/tb_mux_n_to_one_arb.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_n_to_one_arb_pkg.sv
// Shared constants and helpers for the N:1 arbitrated output mux.
package mux_n_to_one_arb_pkg;

    // Arbitration mode selectors for the RR_EN parameter.
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Default per-lane datapath width (ALU/load results).
    localparam int DEF_WIDTH = 64;

    // Lane index width: at least one bit, even for a single lane.
    function automatic int sel_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/mux_n_to_one_arb_if.sv
// Producer-side and consumer-side handshake bundle of the N:1 arbitrated mux.
interface mux_n_to_one_arb_if
    import mux_n_to_one_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = 4
);
    localparam int SEL_W = sel_w(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;

    // Environment side: producers drive lanes, consumer drives out_ready.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );

    // Mux side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

endinterface

// File: rtl/mux_n_to_one_arb_arb_grant_n.sv
// Combinational one-hot grant over requesting lanes, fixed-priority or
// round-robin starting just after the last granted lane.
module arb_grant_n
    import mux_n_to_one_arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             rr_en,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx
);

    logic found_s;
    int   lane_s;

    // Walk the lanes in priority order and grant the first requester.
    always_comb begin
        grant   = {N{1'b0}};
        idx     = {SEL_W{1'b0}};
        found_s = 1'b0;
        lane_s  = 0;
        for (int k = 0; k < N; k++) begin
            if (rr_en) begin
                lane_s = (int'(ptr) + 1 + k) % N;
            end else begin
                lane_s = k;
            end
            if (!found_s && req[lane_s]) begin
                grant[lane_s] = 1'b1;
                idx           = SEL_W'(lane_s);
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mux_n_to_one_arb.sv
// N-input arbitrated mux feeding a single-entry registered output stage with
// a valid/ready handshake. Full throughput: drain and reload in one cycle.
module mux_n_to_one_arb
    import mux_n_to_one_arb_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N     = 4,
    parameter  int RR_EN = ARB_RR,
    localparam int SEL_W = sel_w(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_n_to_one_arb_if.slave  bus
);

    logic [N-1:0]     grant_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic             space_s;
    logic             any_req_s;
    logic             load_s;
    logic             rr_en_s;
    logic [WIDTH-1:0] win_data_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_sel_r;
    logic [SEL_W-1:0] ptr_r;

    assign rr_en_s = (RR_EN != ARB_FIXED);

    arb_grant_n #(
        .N (N)
    ) u_grant (
        .req   (bus.in_valid),
        .ptr   (ptr_r),
        .rr_en (rr_en_s),
        .grant (grant_s),
        .idx   (grant_idx_s)
    );

    // Handshake: the output slot is free when empty or being drained now.
    always_comb begin
        space_s    = ~out_valid_r | bus.out_ready;
        any_req_s  = |bus.in_valid;
        load_s     = space_s & any_req_s;
        win_data_s = bus.in_data[int'(grant_idx_s)*WIDTH +: WIDTH];
        if (rst_n) begin
            bus.in_ready = grant_s & {N{space_s}};
        end else begin
            bus.in_ready = {N{1'b0}};
        end
    end

    // Output register: load the winner, or drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= {SEL_W{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= win_data_s;
            out_sel_r   <= grant_idx_s;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Round-robin pointer: remembers the last granted lane, moves only on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= SEL_W'(N - 1);
        end else if (load_s && rr_en_s) begin
            ptr_r <= grant_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux_n_to_one_arb.sv
// Self-checking bench: a round-robin and a fixed-priority instance receive the
// same stimulus and are compared against a behavioural model of both modes.
module tb_mux_n_to_one_arb;
    import mux_n_to_one_arb_pkg::*;

    localparam int W = 64;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic [N-1:0]   vld;
    logic [N*W-1:0] dat;
    logic           ordy;

    int vectors;
    int miscompares;

    // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];
    int           m_sel   [2];
    int           m_ptr   [2];

    mux_n_to_one_arb_if #(.WIDTH(W), .N(N)) rr_if ();
    mux_n_to_one_arb_if #(.WIDTH(W), .N(N)) fx_if ();

    assign rr_if.in_valid  = vld;
    assign rr_if.in_data   = dat;
    assign rr_if.out_ready = ordy;
    assign fx_if.in_valid  = vld;
    assign fx_if.in_data   = dat;
    assign fx_if.out_ready = ordy;

    mux_n_to_one_arb #(.WIDTH(W), .N(N), .RR_EN(ARB_RR)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rr_if.slave)
    );

    mux_n_to_one_arb #(.WIDTH(W), .N(N), .RR_EN(ARB_FIXED)) dut_fx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fx_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] dut_rdy(input int d);
        return (d == 0) ? rr_if.in_ready : fx_if.in_ready;
    endfunction
    function automatic logic dut_valid(input int d);
        return (d == 0) ? rr_if.out_valid : fx_if.out_valid;
    endfunction
    function automatic logic [W-1:0] dut_data(input int d);
        return (d == 0) ? rr_if.out_data : fx_if.out_data;
    endfunction
    function automatic int dut_sel(input int d);
        return (d == 0) ? int'(rr_if.out_sel) : int'(fx_if.out_sel);
    endfunction

    // Winning lane by the arbitration rule, -1 when nobody requests.
    function automatic int model_grant(input int d, input logic [N-1:0] v);
        if (d == 1) begin
            for (int i = 0; i < N; i++) if (v[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (v[(m_ptr[d] + k) % N]) return (m_ptr[d] + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_sel[d]   = 0;
            m_ptr[d]   = N - 1;
        end
    endfunction

    task automatic set_lane(input int i, input logic [W-1:0] v);
        dat[i*W +: W] = v;
    endtask

    // One clock: check in_ready mid-cycle, clock, then check the output stage.
    task automatic step(input string tag);
        int g [2];
        logic load [2];
        logic [N-1:0] exp_rdy;
        logic space;
        #3;
        for (int d = 0; d < 2; d++) begin
            g[d]    = model_grant(d, vld);
            space   = !m_valid[d] || ordy;
            load[d] = space && (g[d] >= 0);
            exp_rdy = load[d] ? (N'(1) << g[d]) : '0;
            vectors++;
            if (dut_rdy(d) !== exp_rdy) begin
                miscompares++;
                $display("FAIL %s in_ready dut%0d got %b want %b", tag, d, dut_rdy(d), exp_rdy);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (load[d]) begin
                m_valid[d] = 1'b1;
                m_data[d]  = dat[g[d]*W +: W];
                m_sel[d]   = g[d];
                if (d == 0) m_ptr[d] = g[d];
            end else if (m_valid[d] && ordy) begin
                m_valid[d] = 1'b0;
            end
            vectors++;
            if (dut_valid(d) !== m_valid[d] || dut_data(d) !== m_data[d] || dut_sel(d) != m_sel[d]) begin
                miscompares++;
                $display("FAIL %s out dut%0d got v=%b d=%0d s=%0d want v=%b d=%0d s=%0d", tag, d,
                         dut_valid(d), dut_data(d), dut_sel(d), m_valid[d], m_data[d], m_sel[d]);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        vld   = '0;
        ordy  = 1'b0;
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (dut_valid(d) !== 1'b0 || dut_data(d) !== '0 || dut_sel(d) != 0 || dut_rdy(d) !== '0) begin
                miscompares++;
                $display("FAIL reset dut%0d got v=%b d=%0d s=%0d rdy=%b want all zero", d,
                         dut_valid(d), dut_data(d), dut_sel(d), dut_rdy(d));
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_single();
        apply_reset();
        vld  = 4'b0100;
        set_lane(2, 64'd55);
        ordy = 1'b1;
        #2;
        vectors++;
        if (rr_if.in_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_rdy got %b want 0100", rr_if.in_ready);
        end
        step("single_load");
        vectors++;
        if (rr_if.out_valid !== 1'b1 || rr_if.out_data !== 64'd55 || rr_if.out_sel !== 2'd2) begin
            miscompares++;
            $display("FAIL single_out got v=%b d=%0d s=%0d want 1/55/2", rr_if.out_valid, rr_if.out_data, rr_if.out_sel);
        end
        vld = '0;
        step("single_drain");
        vectors++;
        if (rr_if.out_valid !== 1'b0 || rr_if.out_data !== 64'd55) begin
            miscompares++;
            $display("FAIL single_drain got v=%b d=%0d want 0/55", rr_if.out_valid, rr_if.out_data);
        end
    endtask

    task automatic test_round_robin();
        int exp_sel [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        vld  = 4'b1111;
        ordy = 1'b1;
        for (int i = 0; i < N; i++) set_lane(i, W'(10 + i));
        for (int c = 0; c < 5; c++) begin
            step("rr_seq");
            vectors++;
            if (rr_if.out_sel != 2'(exp_sel[c]) || rr_if.out_data !== W'(10 + exp_sel[c]) || rr_if.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_seq cycle %0d got s=%0d d=%0d want s=%0d d=%0d", c,
                         rr_if.out_sel, rr_if.out_data, exp_sel[c], 10 + exp_sel[c]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        vld  = 4'b1010;
        ordy = 1'b1;
        set_lane(1, 64'd73);
        set_lane(3, 64'd42);
        for (int c = 0; c < 3; c++) begin
            step("fixed_hold");
            vectors++;
            if (fx_if.out_data !== 64'd73 || fx_if.out_sel !== 2'd1) begin
                miscompares++;
                $display("FAIL fixed_hold got d=%0d want 73", fx_if.out_data);
            end
        end
        vld = 4'b1000;
        step("fixed_low_gone");
        vectors++;
        if (fx_if.out_data !== 64'd42 || fx_if.out_sel !== 2'd3) begin
            miscompares++;
            $display("FAIL fixed_low_gone got d=%0d want 42", fx_if.out_data);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        vld  = 4'b0001;
        set_lane(0, 64'd27);
        ordy = 1'b1;
        step("bp_load");
        ordy = 1'b0;
        vld  = 4'b1110;
        for (int i = 1; i < N; i++) set_lane(i, W'(200 + i));
        for (int c = 0; c < 3; c++) begin
            step("bp_stall");
            vectors++;
            if (rr_if.out_data !== 64'd27 || fx_if.out_data !== 64'd27 || rr_if.in_ready !== '0 || fx_if.in_ready !== '0) begin
                miscompares++;
                $display("FAIL bp_stall got d=%0d/%0d rdy=%b/%b want 27 and 0000", rr_if.out_data,
                         fx_if.out_data, rr_if.in_ready, fx_if.in_ready);
            end
        end
        ordy = 1'b1;
        step("bp_release");
        vectors++;
        if (rr_if.out_sel !== 2'd1 || rr_if.out_data !== 64'd201 || rr_if.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release got s=%0d d=%0d want s=1 d=201", rr_if.out_sel, rr_if.out_data);
        end
    endtask

    task automatic test_wrap_around();
        apply_reset();
        ordy = 1'b1;
        set_lane(0, 64'd100);
        set_lane(3, 64'd103);
        vld = 4'b1000;
        step("wrap_prime");
        vld = 4'b1001;
        step("wrap_first");
        vectors++;
        if (rr_if.out_sel !== 2'd0 || rr_if.out_data !== 64'd100) begin
            miscompares++;
            $display("FAIL wrap_first got s=%0d want 0", rr_if.out_sel);
        end
        step("wrap_second");
        vectors++;
        if (rr_if.out_sel !== 2'd3 || rr_if.out_data !== 64'd103) begin
            miscompares++;
            $display("FAIL wrap_second got s=%0d want 3", rr_if.out_sel);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ordy = 1'b0;
        vld  = 4'b0010;
        set_lane(1, 64'd98);
        step("mid_load");
        vld = 4'b1111;
        for (int i = 0; i < N; i++) set_lane(i, W'(300 + i));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (rr_if.out_valid !== 1'b0 || rr_if.out_data !== '0 || fx_if.out_valid !== 1'b0 || rr_if.in_ready !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got v=%b d=%0d rdy=%b want 0/0/0000", rr_if.out_valid, rr_if.out_data, rr_if.in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ordy  = 1'b1;
        step("mid_after");
        vectors++;
        if (rr_if.out_sel !== 2'd0 || rr_if.out_data !== 64'd300) begin
            miscompares++;
            $display("FAIL mid_after got s=%0d want 0", rr_if.out_sel);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            vld  = N'($urandom_range(0, 15));
            ordy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) set_lane(i, {$urandom, $urandom});
            step("random");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        vld         = '0;
        dat         = '0;
        ordy        = 1'b0;
        test_reset_single();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_wrap_around();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
